entrada_placar: RTL
===================

ENTRADA_PLACAR -- requirements
Module: entrada_placar

Interface
REQ-001 SHALL have parameter MAX_DIGITOS, default 3, meaning the maximum number of decimal digits accepted per entry (1..3).
REQ-002 SHALL have parameter LARGURA, default 10, meaning the width of the binary accumulator and result.
REQ-003 SHALL have port CLOCK_50  input  1  the single system clock, with all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port digito_valido  input  1  one-cycle strobe qualifying digito.
REQ-006 SHALL have port digito  input  4  decimal digit code, where 0..9 is legal and 10..15 is illegal.
REQ-007 SHALL have port confirma  input  1  one-cycle strobe that commits the entry.
REQ-008 SHALL have port limpa  input  1  one-cycle strobe that discards the entry.
REQ-009 SHALL have port valor  output  LARGURA  running binary value of the entry.
REQ-010 SHALL have port n_digitos  output  2  count of significant digits entered.
REQ-011 SHALL have port resultado  output  LARGURA  last committed value, held until the next commit.
REQ-012 SHALL have port resultado_valido  output  1  one-cycle pulse marking a new resultado.
REQ-013 SHALL have port erro  output  1  one-cycle pulse on each rejected digit.

Function
REQ-014 SHALL implement a four-state FSM:
- VAZIO: n_digitos=0.
- ENTRADA: 0<n_digitos<MAX_DIGITOS.
- CHEIO: n_digitos=MAX_DIGITOS.
- ENTREGA: the single commit cycle.
REQ-015 SHALL, on an accepted digit (digito_valido=1, digito<=9, state VAZIO/ENTRADA), set valor <= valor*10+digito and n_digitos++ at the same edge.
REQ-016 SHALL, in VAZIO with digito=0, keep valor=0 with n_digitos unchanged and no erro, so leading zeros are not counted.
REQ-017 SHALL, for digito>9 in any non-ENTREGA state, leave valor and n_digitos unchanged and pulse erro the next cycle.
REQ-018 SHALL, for a digit in CHEIO, leave valor unchanged and pulse erro the next cycle, with no wrap-around or truncation.
REQ-019 SHALL compute valor*10+digito in LARGURA+4 bits internally and guarantee the result <= 999 for MAX_DIGITOS=3.
REQ-020 SHALL, on confirma in VAZIO/ENTRADA/CHEIO, at the same edge:
- load resultado <= valor,
- clear valor and n_digitos,
- enter ENTREGA.
REQ-021 SHALL assert resultado_valido exactly during the ENTREGA cycle, then go to VAZIO.
REQ-022 SHALL, on confirma in VAZIO, commit resultado=0 with a valid pulse.
REQ-023 SHALL ignore all strobes in ENTREGA, with no erro.
REQ-024 SHALL, on limpa, clear valor and n_digitos, go to VAZIO and leave resultado unchanged, with no pulse.
REQ-025 SHALL apply simultaneous-strobe priority limpa > confirma > digito_valido, where the lower-priority strobe is dropped silently.
REQ-026 SHALL have a commit latency of 1 cycle, from confirma sampled to resultado_valido high.

Reset
REQ-027 SHALL, while reset=0, asynchronously force:
- state to VAZIO,
- valor=0, n_digitos=0, resultado=0,
- resultado_valido=0, erro=0.
REQ-028 SHALL, on reset asserted mid-entry or during ENTREGA, abort without a pulse, with operation resuming on the first edge after reset returns to 1.

Configuration
REQ-029 SHALL, with ECO_DIGITOS_EN defined, add outputs eco0, eco1 and eco2 (4 bits each, eco0 rightmost).
REQ-030 SHALL drive the ECO_DIGITOS_EN echo outputs as follows:
- show the entered digits right-aligned,
- blank positions = code 10,
- all three = 10 after reset, limpa or commit,
- update on the same edge as valor.
REQ-031 SHALL, without ECO_DIGITOS_EN, omit those ports and their registers entirely, with all other behaviour identical.

Structure
REQ-032 SHALL place the state encodings, the BRANCO=10 constant and the VALOR_MAX=999 constant in the shared package/include used by the display blocks.
REQ-033 SHALL be a single module with no sub-module, with arithmetic and FSM inline.

Verification
REQ-034 SHALL cover: digits 1,2,3 then confirma -> valor 1,12,123; resultado=123 with 1-cycle pulse; valor=0 after.
REQ-035 SHALL cover: digits 0,0,7 then confirma -> n_digitos stays 0 until the 7, then 1; resultado=7.
REQ-036 SHALL cover: digits 9,9,9,5 -> the 4th digit raises erro, valor stays 999; digito=12 -> erro, no change.
REQ-037 SHALL cover: limpa and confirma in the same cycle after "45" -> valor=0, no resultado_valido, resultado keeps its prior value.
REQ-038 SHALL cover: reset=0 after "8" and a pending confirma -> all outputs 0, no pulse; post-reset digit 3 -> valor=3.
REQ-039 SHALL cover, with ECO_DIGITOS_EN defined: digits 4,2 -> eco2/eco1/eco0 = 10/4/2.

Source files
------------

// File: rtl/entrada_placar_pkg.sv
// Shared definitions for the score-entry keypad block and the display blocks
// that consume its outputs (state encodings, blank digit code, value ceiling).
package entrada_placar_pkg;

  typedef enum logic [1:0] {
    VAZIO   = 2'd0,
    ENTRADA = 2'd1,
    CHEIO   = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

  localparam logic [3:0] BRANCO    = 4'd10;
  localparam int         VALOR_MAX = 999;

endpackage

// File: rtl/entrada_placar.sv
// Decimal keypad entry: accumulates up to MAX_DIGITOS digits into a binary value
// and commits it on confirma. Define ECO_DIGITOS_EN to add the eco0..eco2 digit echo.
module entrada_placar
  import entrada_placar_pkg::*;
#(
  parameter int MAX_DIGITOS = 3,
  parameter int LARGURA     = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               digito_valido,
  input  logic [3:0]         digito,
  input  logic               confirma,
  input  logic               limpa,
  output logic [LARGURA-1:0] valor,
  output logic [1:0]         n_digitos,
  output logic [LARGURA-1:0] resultado,
  output logic               resultado_valido,
  output logic               erro,
`ifdef ECO_DIGITOS_EN
  output logic [3:0]         eco0,
  output logic [3:0]         eco1,
  output logic [3:0]         eco2,
`endif
  output logic [1:0]         estado
);

  // Strobes are single-cycle qualifiers sampled on the rising edge; there is no
  // back-pressure. Priority among them is limpa > confirma > digito_valido.
  localparam int         W     = LARGURA + 4;
  localparam logic [1:0] N_MAX = 2'(MAX_DIGITOS);

  estado_t              estado_q;
  logic [LARGURA-1:0]   valor_q;
  logic [LARGURA-1:0]   resultado_q;
  logic [1:0]           n_q;
  logic                 valido_q;
  logic                 erro_q;
`ifdef ECO_DIGITOS_EN
  logic [3:0]           eco0_q, eco1_q, eco2_q;
`endif

  logic [W-1:0]         soma;
  logic                 digito_legal;
  logic                 zero_esquerda;
  logic [W-LARGURA-1:0] unused_soma_alta;

  // Widened so the multiply-accumulate never wraps before truncation.
  assign soma             = W'(valor_q) * W'(10) + W'(digito);
  assign unused_soma_alta = soma[W-1:LARGURA];
  assign digito_legal     = (digito <= 4'd9);
  assign zero_esquerda    = (estado_q == VAZIO) && (digito == 4'd0);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado_q    <= VAZIO;
      valor_q     <= '0;
      resultado_q <= '0;
      n_q         <= 2'd0;
      valido_q    <= 1'b0;
      erro_q      <= 1'b0;
`ifdef ECO_DIGITOS_EN
      eco0_q      <= BRANCO;
      eco1_q      <= BRANCO;
      eco2_q      <= BRANCO;
`endif
    end else begin
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
      case (estado_q)
        ENTREGA: estado_q <= VAZIO;
        default: begin
          if (limpa || confirma) begin
            if (!limpa) begin
              resultado_q <= valor_q;
              valido_q    <= 1'b1;
            end
            estado_q <= limpa ? VAZIO : ENTREGA;
            valor_q  <= '0;
            n_q      <= 2'd0;
`ifdef ECO_DIGITOS_EN
            eco0_q   <= BRANCO;
            eco1_q   <= BRANCO;
            eco2_q   <= BRANCO;
`endif
          end else if (digito_valido) begin
            if (!digito_legal || (estado_q == CHEIO)) begin
              erro_q <= 1'b1;
            end else if (!zero_esquerda) begin
              valor_q  <= soma[LARGURA-1:0];
              n_q      <= n_q + 2'd1;
              estado_q <= ((n_q + 2'd1) == N_MAX) ? CHEIO : ENTRADA;
`ifdef ECO_DIGITOS_EN
              eco2_q   <= eco1_q;
              eco1_q   <= eco0_q;
              eco0_q   <= digito;
`endif
            end
          end
        end
      endcase
    end
  end

  assign valor            = valor_q;
  assign n_digitos        = n_q;
  assign resultado        = resultado_q;
  assign resultado_valido = valido_q;
  assign erro             = erro_q;
  assign estado           = 2'(estado_q);
`ifdef ECO_DIGITOS_EN
  assign eco0             = eco0_q;
  assign eco1             = eco1_q;
  assign eco2             = eco2_q;
`endif

endmodule
